// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd15;
    localparam int unsigned TIMEOUT_CNT_W          = $clog2(TIMEOUT_CYCLES_DEFAULT + 32'd1);

    // Counter width able to hold the value `cycles`.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == TIMEOUT_CYCLES_DEFAULT) ? TIMEOUT_CNT_W : $clog2(cycles + 32'd1);
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin selector: first requester after `last_i`, with wrap-around.
module wb_rr_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       last_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]       idx_o
);

    logic found_s;
    int   cand_s;

    // Scan last+1 .. last+NUM_MASTERS so the previous owner is considered last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            cand_s = (int'(last_i) + off) % NUM_MASTERS;
            if (!found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = IDX_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one single-cycle-ack Wishbone slave between masters.
// Optional REQ timeout with m_err_o reporting is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_MASTERS-1:0]             m_stb_i,
    input  logic [NUM_MASTERS-1:0]             m_we_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]             m_ack_o,
    output logic [NUM_MASTERS-1:0]             m_err_o,
    output logic [WB_DATA_WIDTH-1:0]           m_dat_o,
    output logic                               s_stb_o,
    output logic                               s_we_o,
    output logic [WB_ADDR_WIDTH-1:0]           s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]           s_dat_o,
    input  logic                               s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0]           s_dat_i,
    output logic [NUM_MASTERS-1:0]             grant_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int AW    = WB_ADDR_WIDTH;
    localparam int DW    = WB_DATA_WIDTH;

    arb_state_e             state_r;
    logic [IDX_W-1:0]       last_r;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [NUM_MASTERS-1:0] m_ack_r;
    logic [DW-1:0]          m_dat_r;
    logic                   s_stb_r;
    logic                   s_we_r;
    logic [AW-1:0]          s_adr_r;
    logic [DW-1:0]          s_dat_r;
    logic [NUM_MASTERS-1:0] pick_grant_s;
    logic [IDX_W-1:0]       pick_idx_s;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]       tmo_cnt_r;
    logic [NUM_MASTERS-1:0] m_err_r;
`endif

    wb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req_i   (m_stb_i),
        .last_i  (last_r),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s)
    );

    // Arbitration FSM; every bus-facing output is a register of this block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            last_r    <= IDX_W'(NUM_MASTERS - 1);
            grant_r   <= '0;
            m_ack_r   <= '0;
            m_dat_r   <= '0;
            s_stb_r   <= 1'b0;
            s_we_r    <= 1'b0;
            s_adr_r   <= '0;
            s_dat_r   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt_r <= '0;
            m_err_r   <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|m_stb_i) begin
                        grant_r <= pick_grant_s;
                        last_r  <= pick_idx_s;
                        s_stb_r <= 1'b1;
                        s_we_r  <= m_we_i[pick_idx_s];
                        s_adr_r <= m_adr_i[pick_idx_s*AW +: AW];
                        s_dat_r <= m_dat_i[pick_idx_s*DW +: DW];
`ifdef WB_ARB_TIMEOUT_EN
                        tmo_cnt_r <= '0;
`endif
                        state_r <= ST_REQ;
                    end else begin
                        grant_r <= '0;
                        s_stb_r <= 1'b0;
                        s_we_r  <= 1'b0;
                        s_adr_r <= '0;
                        s_dat_r <= '0;
                    end
                end
                ST_REQ: begin
                    // Ack has priority over a coinciding timeout.
                    if (s_ack_i) begin
                        m_ack_r <= grant_r;
                        m_dat_r <= s_dat_i;
                        s_stb_r <= 1'b0;
                        state_r <= ST_DONE;
`ifdef WB_ARB_TIMEOUT_EN
                    end else if (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        m_err_r <= grant_r;
                        m_dat_r <= '0;
                        s_stb_r <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
`else
                    end else begin
                        state_r <= ST_REQ;
`endif
                    end
                end
                ST_DONE: begin
                    // Recovery cycle: the slave's trailing duplicate ack is dropped here.
                    m_ack_r <= '0;
                    grant_r <= '0;
                    s_we_r  <= 1'b0;
                    s_adr_r <= '0;
                    s_dat_r <= '0;
`ifdef WB_ARB_TIMEOUT_EN
                    m_err_r <= '0;
`endif
                    state_r <= ST_IDLE;
                end
                default: begin
                    m_ack_r <= '0;
                    grant_r <= '0;
                    s_stb_r <= 1'b0;
                    s_we_r  <= 1'b0;
                    s_adr_r <= '0;
                    s_dat_r <= '0;
`ifdef WB_ARB_TIMEOUT_EN
                    m_err_r <= '0;
`endif
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ack_o = m_ack_r;
    assign m_dat_o = m_dat_r;
    assign s_stb_o = s_stb_r;
    assign s_we_o  = s_we_r;
    assign s_adr_o = s_adr_r;
    assign s_dat_o = s_dat_r;
    assign grant_o = grant_r;
`ifdef WB_ARB_TIMEOUT_EN
    assign m_err_o = m_err_r;
`else
    assign m_err_o = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with a registered single-cycle-ack slave model.
module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk_i;
    logic          rst_ni;
    logic [N-1:0]  m_stb_i;
    logic [N-1:0]  m_we_i;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] dat0, dat1;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N-1:0]  m_ack_o;
    logic [N-1:0]  m_err_o;
    logic [DW-1:0] m_dat_o;
    logic          s_stb_o;
    logic          s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_ack_i;
    logic [DW-1:0] s_dat_i;
    logic [N-1:0]  grant_o;
    logic          slave_en;

    int n_tests = 0;
    int n_fail  = 0;

    assign m_adr_i = {adr1, adr0};
    assign m_dat_i = {dat1, dat0};

    wb_arbiter #(
        .NUM_MASTERS    (N),
        .WB_DATA_WIDTH  (DW),
        .WB_ADDR_WIDTH  (AW),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i),
        .grant_o (grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Slave acks every cycle its strobe was sampled high, so each ack lasts two cycles.
    always_ff @(posedge clk_i) s_ack_i <= slave_en & s_stb_o;

    // Read data depends on address: adr 1 -> 0x11, adr 2 -> 0x22.
    assign s_dat_i = (s_adr_o == 2'd1) ? 8'h11 : (s_adr_o == 2'd2) ? 8'h22 : 8'h5C;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [N-1:0]  exp_own [4];
    logic [DW-1:0] exp_dat [4];

    initial begin
        rst_ni   = 1'b0;
        m_stb_i  = '0;
        m_we_i   = '0;
        adr0 = '0; adr1 = '0; dat0 = '0; dat1 = '0;
        s_ack_i  = 1'b0;
        slave_en = 1'b1;

        // Reset state
        tick(); tick();
        check("reset_outputs", 32'({m_ack_o, m_err_o, m_dat_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o}), 32'd0);
        #2 rst_ni = 1'b1;
        tick();
        check("post_reset_grant", 32'(grant_o), 32'd0);
        check("post_reset_stb", 32'(s_stb_o), 32'd0);

        // Single write by master 0
        m_stb_i = 2'b01; m_we_i = 2'b01; adr0 = 2'd2; dat0 = 8'hA5;
        tick();
        check("wr_stb", 32'(s_stb_o), 32'd1);
        check("wr_adr", 32'(s_adr_o), 32'd2);
        check("wr_dat", 32'(s_dat_o), 32'hA5);
        check("wr_we", 32'(s_we_o), 32'd1);
        check("wr_grant", 32'(grant_o), 32'b01);
        check("wr_no_early_ack", 32'(m_ack_o), 32'd0);
        tick();
        check("wr_no_ack_req2", 32'(m_ack_o), 32'd0);
        check("wr_hold_adr", 32'(s_adr_o), 32'd2);
        tick();
        check("wr_ack", 32'(m_ack_o), 32'b01);
        check("wr_ack_dat", 32'(m_dat_o), 32'h22);
        check("wr_stb_drop", 32'(s_stb_o), 32'd0);
        m_stb_i = 2'b00; m_we_i = 2'b00;
        tick();
        check("wr_ack_single", 32'(m_ack_o), 32'd0);
        check("wr_grant_clear", 32'(grant_o), 32'd0);
        tick();
        check("wr_no_second_ack", 32'(m_ack_o), 32'd0);
        check("wr_dat_hold", 32'(m_dat_o), 32'h22);

        // Contention: master 0 owned last, so master 1 leads and ownership alternates
        exp_own[0] = 2'b10; exp_own[1] = 2'b01; exp_own[2] = 2'b10; exp_own[3] = 2'b01;
        exp_dat[0] = 8'h22; exp_dat[1] = 8'h11; exp_dat[2] = 8'h22; exp_dat[3] = 8'h11;
        adr0 = 2'd1; adr1 = 2'd2;
        m_stb_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("rr_grant_%0d", t), 32'(grant_o), 32'(exp_own[t]));
            tick();
            check($sformatf("rr_wait_%0d", t), 32'(m_ack_o), 32'd0);
            tick();
            check($sformatf("rr_ack_%0d", t), 32'(m_ack_o), 32'(exp_own[t]));
            check($sformatf("rr_dat_%0d", t), 32'(m_dat_o), 32'(exp_dat[t]));
            tick();
            check($sformatf("rr_dup_ack_%0d", t), 32'(m_ack_o), 32'd0);
            check($sformatf("rr_idle_%0d", t), 32'(grant_o), 32'd0);
        end
        m_stb_i = 2'b00;
        tick();

        // Reset in the middle of REQ
        m_stb_i = 2'b10;
        tick();
        check("rst_pre_grant", 32'(grant_o), 32'b10);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_stb_async", 32'(s_stb_o), 32'd0);
        check("rst_no_ack", 32'(m_ack_o), 32'd0);
        check("rst_grant", 32'(grant_o), 32'd0);
        m_stb_i = 2'b11;
        tick();
        rst_ni = 1'b1;
        tick();
        check("rst_m0_first", 32'(grant_o), 32'b01);
        tick(); tick();
        check("rst_m0_ack", 32'(m_ack_o), 32'b01);
        m_stb_i = 2'b00;
        tick(); tick();

        // No ack from the slave
        slave_en = 1'b0;
        m_stb_i = 2'b10; m_we_i = 2'b00; adr1 = 2'd2;
        tick();
        check("to_grant", 32'(grant_o), 32'b10);
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c < 15; c++) tick();
        check("to_not_yet", 32'(m_err_o), 32'd0);
        check("to_stb_held", 32'(s_stb_o), 32'd1);
        tick();
        check("to_err", 32'(m_err_o), 32'b10);
        check("to_no_ack", 32'(m_ack_o), 32'd0);
        check("to_dat_zero", 32'(m_dat_o), 32'd0);
        check("to_stb_drop", 32'(s_stb_o), 32'd0);
        m_stb_i = 2'b00;
        tick();
        check("to_err_pulse", 32'(m_err_o), 32'd0);
        check("to_idle", 32'(grant_o), 32'd0);
        slave_en = 1'b1;
`else
        for (int c = 0; c < 100; c++) tick();
        check("hang_stb", 32'(s_stb_o), 32'd1);
        check("hang_grant", 32'(grant_o), 32'b10);
        check("hang_no_ack", 32'(m_ack_o), 32'd0);
        check("hang_no_err", 32'(m_err_o), 32'd0);
        slave_en = 1'b1;
        tick(); tick();
        check("hang_late_ack", 32'(m_ack_o), 32'b10);
        check("hang_late_dat", 32'(m_dat_o), 32'h22);
        m_stb_i = 2'b00;
        tick();
        check("hang_idle", 32'(grant_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
